// File: rtl/multi_cycle_pkg.sv
// rtl/multi_cycle_pkg.sv - shared encodings for the multi-cycle MIPS-subset control unit
package multi_cycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALUOP_ADD   = 3'd0;
    localparam logic [2:0] ALUOP_SUB   = 3'd1;
    localparam logic [2:0] ALUOP_RTYPE = 3'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;

    localparam logic [1:0] WB_ALUOUT  = 2'd0;
    localparam logic [1:0] WB_MDR     = 2'd1;
    localparam logic [1:0] WB_LINK    = 2'd2;
    localparam logic [1:0] WB_LUI_IMM = 2'd3;

    // FETCH is zero so the debug state reads 0 while reset is held
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_WB_I     = 4'd5,
        ST_WB_LUI   = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WB   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd13
    } state_e;

    function automatic logic is_jr(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) && (funct == FN_JR);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// rtl/multi_cycle_ctrl_if.sv - unified memory port handshake between control unit and memory
interface multi_cycle_ctrl_if;

    logic mem_req_o;
    logic mem_we_o;
    logic iord_o;
    logic mem_ready_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output iord_o,
        input  mem_ready_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  iord_o,
        output mem_ready_i
    );

endinterface

// File: rtl/multi_cycle_ctrl_sat_counter.sv
// rtl/multi_cycle_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clear_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle control FSM sequencing shared ALU and unified memory port
module multi_cycle_ctrl
    import multi_cycle_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [5:0]           op_i,
    input  logic [5:0]           funct_i,
    input  logic                 alu_zero_i,
    multi_cycle_ctrl_if.master   mem,
    output logic                 ir_write_o,
    output logic                 pc_write_o,
    output logic [1:0]           pc_src_o,
    output logic                 alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [2:0]           alu_op_o,
    output logic                 reg_write_o,
    output logic [1:0]           reg_dst_o,
    output logic [1:0]           wb_src_o,
    output logic [3:0]           state_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     cycle_cnt_o,
    output logic [CNT_W-1:0]     instr_cnt_o
);

    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;
    logic       retire;
    logic       tmo_hit;
    logic [7:0] tmo_inc;

    logic       mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c;
    logic       alu_src_a_c, reg_write_c;
    logic [1:0] pc_src_c, alu_src_b_c, reg_dst_c, wb_src_c;
    logic [2:0] alu_op_c;

    // the current wait cycle is the last one allowed before a trap
    assign tmo_hit = (tmo_q == (TMO_LIMIT - 8'd1));
    assign tmo_inc = tmo_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        tmo_d       = '0;
        retire      = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        iord_c      = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = PCSRC_ALU;
        alu_src_a_c = 1'b0;
        alu_src_b_c = SRCB_RT;
        alu_op_c    = ALUOP_ADD;
        reg_write_c = 1'b0;
        reg_dst_c   = RDST_RT;
        wb_src_c    = WB_ALUOUT;

        case (state_q)
            ST_FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                if (mem.mem_ready_i) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = ST_DECODE;
                end else if (tmo_hit) begin
                    state_d = ST_TRAP;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            ST_DECODE: begin
                alu_src_b_c = SRCB_IMM_SH2;
                case (op_i)
                    OP_RTYPE:      state_d = is_jr(op_i, funct_i) ? ST_JUMP : ST_EXEC_R;
                    OP_ADDI:       state_d = ST_EXEC_I;
                    OP_LUI:        state_d = ST_WB_LUI;
                    OP_LW, OP_SW:  state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                    OP_J, OP_JAL:  state_d = ST_JUMP;
                    default:       state_d = ST_TRAP;
                endcase
            end
            ST_EXEC_R: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALUOP_RTYPE;
                state_d     = ST_WB_R;
            end
            ST_WB_R: begin
                reg_write_c = 1'b1;
                reg_dst_c   = RDST_RD;
                retire      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_EXEC_I: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                state_d     = ST_WB_I;
            end
            ST_WB_I: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_WB_LUI: begin
                reg_write_c = 1'b1;
                wb_src_c    = WB_LUI_IMM;
                retire      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                state_d     = (op_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (mem.mem_ready_i) begin
                    state_d = ST_MEM_WB;
                end else if (tmo_hit) begin
                    state_d = ST_TRAP;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            ST_MEM_WB: begin
                reg_write_c = 1'b1;
                wb_src_c    = WB_MDR;
                retire      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord_c    = 1'b1;
                if (mem.mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (tmo_hit) begin
                    state_d = ST_TRAP;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            ST_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALUOP_SUB;
                pc_src_c    = PCSRC_ALUOUT;
                pc_write_c  = alu_zero_i ^ (op_i == OP_BNE);
                retire      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write_c = 1'b1;
                pc_src_c   = is_jr(op_i, funct_i) ? PCSRC_RS : PCSRC_JUMP;
                if (op_i == OP_JAL) begin
                    reg_write_c = 1'b1;
                    reg_dst_c   = RDST_RA;
                    wb_src_c    = WB_LINK;
                end
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase

        err_d = err_q | (state_d == ST_TRAP);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // gating with rst_n drops every enable the instant reset falls, abandoning any write
    assign mem.mem_req_o = rst_n & mem_req_c;
    assign mem.mem_we_o  = rst_n & mem_we_c;
    assign mem.iord_o    = rst_n & iord_c;
    assign ir_write_o    = rst_n & ir_write_c;
    assign pc_write_o    = rst_n & pc_write_c;
    assign pc_src_o      = rst_n ? pc_src_c    : 2'd0;
    assign alu_src_a_o   = rst_n & alu_src_a_c;
    assign alu_src_b_o   = rst_n ? alu_src_b_c : 2'd0;
    assign alu_op_o      = rst_n ? alu_op_c    : 3'd0;
    assign reg_write_o   = rst_n & reg_write_c;
    assign reg_dst_o     = rst_n ? reg_dst_c   : 2'd0;
    assign wb_src_o      = rst_n ? wb_src_c    : 2'd0;
    assign state_o       = state_q;
    assign err_o         = err_q;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .inc_i   (1'b1),
        .clear_i (1'b0),
        .cnt_o   (cycle_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .inc_i   (retire),
        .clear_i (1'b0),
        .cnt_o   (instr_cnt_o)
    );

endmodule
